// File: rtl/pll_reset_sequencer.sv
// Turns the asynchronous PLL lock flag into ordered synchronous resets.
// Release order: video, then SDRAM (gated by its ready handshake), then CPU.
module pll_reset_sequencer #(
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int SDRAM_RST_HOLD     = 16,
   parameter int READY_TIMEOUT      = 65535,
   parameter int CPU_DELAY          = 256
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       pll_locked,
   input  logic       sdram_ready,
   output logic       rst_video,
   output logic       rst_sdram,
   output logic       rst_cpu,
   output logic [2:0] seq_state,
   output logic [7:0] lock_loss_count,
   output logic       sdram_timeout
);

   typedef enum logic [2:0] {
      ST_WAIT_LOCK  = 3'd0,
      ST_STABLE     = 3'd1,
      ST_SDRAM_HOLD = 3'd2,
      ST_WAIT_READY = 3'd3,
      ST_CPU_DELAY  = 3'd4,
      ST_RUN        = 3'd5
   } seqState_t;

   localparam logic [19:0] LOCK_LAST  = 20'(LOCK_STABLE_CYCLES - 1);
   localparam logic [19:0] HOLD_LAST  = 20'(SDRAM_RST_HOLD - 1);
   localparam logic [19:0] READY_LAST = 20'(READY_TIMEOUT - 1);
   localparam logic [19:0] CPU_LAST   = 20'(CPU_DELAY - 1);

   seqState_t   state_q, state_d;
   logic [19:0] count_q, count_d;
   logic [7:0]  lossCount_q, lossCount_d;
   logic        timeout_q, timeout_d;
   logic        syncFirst_q, lockedSync_q;
   logic        rstVideo_q, rstVideo_d;
   logic        rstSdram_q, rstSdram_d;
   logic        rstCpu_q, rstCpu_d;

   always_ff @(posedge clock) begin
      if (reset) begin
         syncFirst_q  <= 1'b0;
         lockedSync_q <= 1'b0;
         state_q      <= ST_WAIT_LOCK;
         count_q      <= '0;
         lossCount_q  <= '0;
         timeout_q    <= 1'b0;
         rstVideo_q   <= 1'b1;
         rstSdram_q   <= 1'b1;
         rstCpu_q     <= 1'b1;
      end else begin
         syncFirst_q  <= pll_locked;
         lockedSync_q <= syncFirst_q;
         state_q      <= state_d;
         count_q      <= count_d;
         lossCount_q  <= lossCount_d;
         timeout_q    <= timeout_d;
         rstVideo_q   <= rstVideo_d;
         rstSdram_q   <= rstSdram_d;
         rstCpu_q     <= rstCpu_d;
      end
   end

   // The shared counter restarts at zero on every state entry; lock loss overrides all else.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q + 20'd1;
      lossCount_d = lossCount_q;
      timeout_d   = timeout_q;
      if (state_q != ST_WAIT_LOCK && !lockedSync_q) begin
         state_d = ST_WAIT_LOCK;
         count_d = '0;
         if (lossCount_q != 8'hFF) begin
            lossCount_d = lossCount_q + 8'd1;
         end
      end else begin
         case (state_q)
            ST_WAIT_LOCK: begin
               count_d = '0;
               if (lockedSync_q) begin
                  state_d = ST_STABLE;
               end
            end
            ST_STABLE: begin
               if (count_q == LOCK_LAST) begin
                  state_d = ST_SDRAM_HOLD;
                  count_d = '0;
               end
            end
            ST_SDRAM_HOLD: begin
               if (count_q == HOLD_LAST) begin
                  state_d = ST_WAIT_READY;
                  count_d = '0;
               end
            end
            ST_WAIT_READY: begin
               if (sdram_ready) begin
                  state_d = ST_CPU_DELAY;
                  count_d = '0;
               end else if (count_q == READY_LAST) begin
                  state_d   = ST_SDRAM_HOLD;
                  count_d   = '0;
                  timeout_d = 1'b1;
               end
            end
            ST_CPU_DELAY: begin
               if (!sdram_ready) begin
                  state_d = ST_WAIT_READY;
                  count_d = '0;
               end else if (count_q == CPU_LAST) begin
                  state_d = ST_RUN;
                  count_d = '0;
               end
            end
            ST_RUN: begin
               count_d = '0;
            end
            default: begin
               state_d = ST_WAIT_LOCK;
               count_d = '0;
            end
         endcase
      end
      rstVideo_d = (state_d == ST_WAIT_LOCK) || (state_d == ST_STABLE);
      rstSdram_d = rstVideo_d || (state_d == ST_SDRAM_HOLD);
      rstCpu_d   = (state_d != ST_RUN);
   end

   assign rst_video       = rstVideo_q;
   assign rst_sdram       = rstSdram_q;
   assign rst_cpu         = rstCpu_q;
   assign seq_state       = state_q;
   assign lock_loss_count = lossCount_q;
   assign sdram_timeout   = timeout_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed/randomized bench for pll_reset_sequencer against a timestamp-based reference model.
// Each step drives inputs, crosses one clock edge, advances the model and compares every output.
module tb_pll_reset_sequencer;

   localparam int LOCK_STABLE = 8;
   localparam int HOLD_CYC    = 4;
   localparam int TIMEOUT_CYC = 20;
   localparam int CPU_CYC     = 6;

   localparam int PH_WAIT_LOCK  = 0;
   localparam int PH_STABLE     = 1;
   localparam int PH_SDRAM_HOLD = 2;
   localparam int PH_WAIT_READY = 3;
   localparam int PH_CPU_DELAY  = 4;
   localparam int PH_RUN        = 5;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       pllLocked = 1'b0;
   logic       sdramReady = 1'b0;
   logic       rstVideo, rstSdram, rstCpu, sdramTimeout;
   logic [2:0] seqState;
   logic [7:0] lockLossCount;

   int assertCount = 0;
   int failCount   = 0;

   bit mSync1, mLockedS, mTimeout;
   int mPhase, mEntry, mLoss, edgeNum;

   pll_reset_sequencer #(
      .LOCK_STABLE_CYCLES(LOCK_STABLE),
      .SDRAM_RST_HOLD(HOLD_CYC),
      .READY_TIMEOUT(TIMEOUT_CYC),
      .CPU_DELAY(CPU_CYC)
   ) dut (
      .clock(clock),
      .reset(reset),
      .pll_locked(pllLocked),
      .sdram_ready(sdramReady),
      .rst_video(rstVideo),
      .rst_sdram(rstSdram),
      .rst_cpu(rstCpu),
      .seq_state(seqState),
      .lock_loss_count(lockLossCount),
      .sdram_timeout(sdramTimeout)
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic enterPhase(input int ph);
      mPhase = ph;
      mEntry = edgeNum;
   endtask

   // Phases are left when the time since entry reaches the stated dwell length.
   task automatic modelEdge(input bit lockIn, input bit readyIn, input bit rstIn);
      bit seenLocked;
      int dwell;
      edgeNum++;
      if (rstIn) begin
         mSync1   = 1'b0;
         mLockedS = 1'b0;
         mTimeout = 1'b0;
         mLoss    = 0;
         enterPhase(PH_WAIT_LOCK);
         return;
      end
      seenLocked = mLockedS;
      mLockedS   = mSync1;
      mSync1     = lockIn;
      dwell      = edgeNum - mEntry;
      if (mPhase != PH_WAIT_LOCK && !seenLocked) begin
         enterPhase(PH_WAIT_LOCK);
         mLoss = (mLoss < 255) ? mLoss + 1 : 255;
      end else begin
         case (mPhase)
            PH_WAIT_LOCK:  if (seenLocked) enterPhase(PH_STABLE);
            PH_STABLE:     if (dwell == LOCK_STABLE) enterPhase(PH_SDRAM_HOLD);
            PH_SDRAM_HOLD: if (dwell == HOLD_CYC) enterPhase(PH_WAIT_READY);
            PH_WAIT_READY: begin
               if (readyIn) enterPhase(PH_CPU_DELAY);
               else if (dwell == TIMEOUT_CYC) begin
                  mTimeout = 1'b1;
                  enterPhase(PH_SDRAM_HOLD);
               end
            end
            PH_CPU_DELAY: begin
               if (!readyIn) enterPhase(PH_WAIT_READY);
               else if (dwell == CPU_CYC) enterPhase(PH_RUN);
            end
            default: ;
         endcase
      end
   endtask

   task automatic checkValue(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      assertCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s at edge %0d: observed %0d expected %0d", tag, edgeNum, observed, expected);
      end
   endtask

   task automatic checkOutput();
      checkValue("rst_video", 16'(rstVideo), 16'(mPhase <= PH_STABLE));
      checkValue("rst_sdram", 16'(rstSdram), 16'(mPhase <= PH_SDRAM_HOLD));
      checkValue("rst_cpu", 16'(rstCpu), 16'(mPhase != PH_RUN));
      checkValue("seq_state", 16'(seqState), 16'(mPhase));
      checkValue("lock_loss_count", 16'(lockLossCount), 16'(mLoss));
      checkValue("sdram_timeout", 16'(sdramTimeout), 16'(mTimeout));
   endtask

   task automatic applyStimulus(input bit lockIn, input bit readyIn, input bit rstIn);
      pllLocked  = lockIn;
      sdramReady = readyIn;
      reset      = rstIn;
      @(posedge clock);
      modelEdge(lockIn, readyIn, rstIn);
      #1;
      checkOutput();
   endtask

   task automatic checkResetState(input string tag);
      checkValue({tag, " rst_video"}, 16'(rstVideo), 16'd1);
      checkValue({tag, " rst_sdram"}, 16'(rstSdram), 16'd1);
      checkValue({tag, " rst_cpu"}, 16'(rstCpu), 16'd1);
      checkValue({tag, " seq_state"}, 16'(seqState), 16'd0);
      checkValue({tag, " lock_loss_count"}, 16'(lockLossCount), 16'd0);
      checkValue({tag, " sdram_timeout"}, 16'(sdramTimeout), 16'd0);
   endtask

   task automatic doReset();
      applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkResetState("reset");
   endtask

   initial begin
      int glitchEdge, dropEdge, reEdge, lossEdge, hiLen, loLen;
      edgeNum = 0;
      enterPhase(PH_WAIT_LOCK);
      mLoss = 0;

      $display("[TB] nominal power-up");
      doReset();
      for (int i = 1; i <= 30; i++) begin
         applyStimulus(1'b1, i >= 18, 1'b0);
         if (i == 10) checkValue("pwr rst_video before", 16'(rstVideo), 16'd1);
         if (i == 11) checkValue("pwr rst_video release", 16'(rstVideo), 16'd0);
         if (i == 14) checkValue("pwr rst_sdram before", 16'(rstSdram), 16'd1);
         if (i == 15) checkValue("pwr rst_sdram release", 16'(rstSdram), 16'd0);
         if (i == 23) checkValue("pwr rst_cpu before", 16'(rstCpu), 16'd1);
         if (i == 24) begin
            checkValue("pwr rst_cpu release", 16'(rstCpu), 16'd0);
            checkValue("pwr seq_state run", 16'(seqState), 16'd5);
         end
      end

      $display("[TB] lock glitch during stable");
      for (int v = 0; v < 2; v++) begin
         glitchEdge = (v == 0) ? 6 : int'($urandom_range(2, 9));
         doReset();
         for (int i = 1; i <= glitchEdge + 14; i++) begin
            applyStimulus(i != glitchEdge, 1'b0, 1'b0);
            if (i == glitchEdge + 10) checkValue("glitch rst_video held", 16'(rstVideo), 16'd1);
            if (i == glitchEdge + 11) checkValue("glitch rst_video release", 16'(rstVideo), 16'd0);
         end
         checkValue("glitch lock_loss_count", 16'(lockLossCount), 16'd1);
      end

      $display("[TB] lock loss in run");
      doReset();
      lossEdge = 24 + int'($urandom_range(1, 10));
      for (int i = 1; i <= lossEdge + 4; i++) begin
         applyStimulus(i < lossEdge, i >= 18, 1'b0);
         if (i == lossEdge + 1) checkValue("run rst_cpu still low", 16'(rstCpu), 16'd0);
         if (i == lossEdge + 2) begin
            checkValue("run all resets high", 16'({rstVideo, rstSdram, rstCpu}), 16'd7);
            checkValue("run lock_loss_count", 16'(lockLossCount), 16'd1);
         end
      end

      $display("[TB] sdram never ready");
      doReset();
      for (int i = 1; i <= 90; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0);
         if (i == 34) checkValue("timeout flag before", 16'(sdramTimeout), 16'd0);
         if (i == 35) begin
            checkValue("timeout flag set", 16'(sdramTimeout), 16'd1);
            checkValue("timeout rst_sdram pulse", 16'(rstSdram), 16'd1);
         end
         if (i == 38) checkValue("timeout rst_sdram held", 16'(rstSdram), 16'd1);
         if (i == 39) checkValue("timeout rst_sdram retry", 16'(rstSdram), 16'd0);
         if (i == 59) checkValue("timeout second retry", 16'(rstSdram), 16'd1);
      end
      checkValue("timeout rst_cpu", 16'(rstCpu), 16'd1);

      $display("[TB] sdram_ready drop during cpu delay");
      doReset();
      dropEdge = 18 + int'($urandom_range(1, 5));
      reEdge   = dropEdge + int'($urandom_range(1, 5));
      for (int i = 1; i <= reEdge + 8; i++) begin
         applyStimulus(1'b1, (i >= 18 && i < dropEdge) || i >= reEdge, 1'b0);
         if (i == dropEdge) begin
            checkValue("drop seq_state", 16'(seqState), 16'd3);
            checkValue("drop rst_cpu", 16'(rstCpu), 16'd1);
         end
         if (i == reEdge + 5) checkValue("redelay rst_cpu held", 16'(rstCpu), 16'd1);
         if (i == reEdge + 6) checkValue("redelay rst_cpu release", 16'(rstCpu), 16'd0);
      end

      $display("[TB] lock loss saturation and mid-sequence reset");
      doReset();
      for (int n = 0; n < 300; n++) begin
         hiLen = int'($urandom_range(2, 6));
         loLen = int'($urandom_range(2, 4));
         for (int i = 0; i < hiLen; i++) applyStimulus(1'b1, $urandom_range(0, 1) == 1, 1'b0);
         for (int i = 0; i < loLen; i++) applyStimulus(1'b0, 1'b0, 1'b0);
      end
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0);
      checkValue("saturated lock_loss_count", 16'(lockLossCount), 16'd255);
      for (int i = 1; i <= 20; i++) applyStimulus(1'b1, i >= 18, 1'b0);
      checkValue("mid cpu_delay seq_state", 16'(seqState), 16'd4);
      applyStimulus(1'b1, 1'b1, 1'b1);
      checkResetState("mid-sequence reset");
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0);

      $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
